// File: rtl/hbridge_monitor_pkg.sv
// hbridge_monitor_pkg: gate-drive pattern constants, class and FSM encodings, pattern classifier
package hbridge_monitor_pkg;
  localparam logic [3:0] HB_OFF   = 4'b0000;
  localparam logic [3:0] HB_A     = 4'b1001;
  localparam logic [3:0] HB_B     = 4'b0110;
  localparam logic [3:0] HB_BRAKE = 4'b1010;
  localparam int DEAD_TIME_DEF = 10;
  localparam int CNT_W_DEF     = 16;
  localparam int PERIOD_LENGTH = 99;
  // Low two bits of the active classes double as the last_active code and accumulator index.
  typedef enum logic [2:0] {CL_OFF = 3'd0, CL_A = 3'd1, CL_B = 3'd2, CL_BRAKE = 3'd3, CL_ILL = 3'd4} hb_class_e;
  typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DEAD} hb_state_e;
  function automatic hb_class_e classify(input logic [3:0] hb);
    return hb == HB_OFF ? CL_OFF : hb == HB_A ? CL_A : hb == HB_B ? CL_B : hb == HB_BRAKE ? CL_BRAKE : CL_ILL;
  endfunction
endpackage

// File: rtl/hbridge_deadtime_checker.sv
// hbridge_deadtime_checker: drive/dead-time FSM; ports cls_i (class), dt_pulse_o (violation this cycle), last_active_o
module hbridge_deadtime_checker
  import hbridge_monitor_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] cls_i,
  output logic       dt_pulse_o,
  output logic [1:0] last_active_o
);
  localparam int ZW = $clog2(DEAD_TIME + 1);
  localparam logic [ZW-1:0] DT = ZW'(DEAD_TIME);
  hb_state_e state_q, state_d;
  logic [1:0] pat_q, pat_d, last_q, last_d;
  logic [ZW-1:0] zr_q, zr_d;
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    last_d = last_q;
    zr_d = zr_q;
    dt_pulse_o = 1'b0;
    if (cls_i == CL_ILL) begin
      state_d = ST_IDLE;
    end else if (cls_i == CL_OFF) begin
      state_d = state_q == ST_IDLE ? ST_IDLE : ST_DEAD;
      zr_d = state_q == ST_DRIVE ? ZW'(1) : (zr_q < DT ? zr_q + 1'b1 : zr_q);
    end else begin
      state_d = ST_DRIVE;
      pat_d = cls_i[1:0];
      last_d = cls_i[1:0];
      // Re-entering the same leg after OFF is ordinary PWM, never a violation.
      dt_pulse_o = cls_i[1:0] != pat_q && (state_q == ST_DRIVE || (state_q == ST_DEAD && zr_q < DT));
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q <= 2'd0;
      last_q <= 2'd0;
      zr_q <= DT;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      last_q <= last_d;
      zr_q <= zr_d;
    end
  end
  assign last_active_o = last_q;
endmodule

// File: rtl/hbridge_monitor.sv
// hbridge_monitor: H-bridge gate-bus decoder with window occupancy counters and sticky dead-time/shoot-through faults
//   in : clk, reset (sync, active high), hb_in[3:0], period[CNT_W-1:0] (window-1), clr_fault
//   out: meas_valid, cnt_a/cnt_b/cnt_brake/cnt_off[CNT_W-1:0], last_active[1:0], fault_shoot, fault_dt
//   HBRIDGE_MON_SYNC_EN: when defined, hb_in passes a 2-flop synchronizer (+2 cycles latency)
module hbridge_monitor
  import hbridge_monitor_pkg::*;
#(
  parameter int DEAD_TIME = DEAD_TIME_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       hb_in,
  input  logic [CNT_W-1:0] period,
  input  logic             clr_fault,
  output logic             meas_valid,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_brake,
  output logic [CNT_W-1:0] cnt_off,
  output logic [1:0]       last_active,
  output logic             fault_shoot,
  output logic             fault_dt
);
  logic [3:0] hb;
`ifdef HBRIDGE_MON_SYNC_EN
  logic [3:0] sync1_q, sync2_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= HB_OFF;
      sync2_q <= HB_OFF;
    end else begin
      sync1_q <= hb_in;
      sync2_q <= sync1_q;
    end
  end
  assign hb = sync2_q;
`else
  assign hb = hb_in;
`endif
  logic [2:0] cls;
  logic dt_pulse, end_win, mv_q, fs_q, fd_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] acc_q [4];
  logic [CNT_W-1:0] acc_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  assign cls = classify(hb);
  hbridge_deadtime_checker #(.DEAD_TIME(DEAD_TIME)) u_dt (
    .clk          (clk),
    .reset        (reset),
    .cls_i        (cls),
    .dt_pulse_o   (dt_pulse),
    .last_active_o(last_active)
  );
  // Live compare so a period lowered below the running count closes the window at once.
  assign end_win = wcnt_q >= period;
  // Accumulators include the current cycle and stick at all-ones; ILLEGAL matches no index.
  always_comb begin
    for (int i = 0; i < 4; i++)
      acc_d[i] = (cls == 3'(i) && !(&acc_q[i])) ? acc_q[i] + 1'b1 : acc_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= '0;
      mv_q <= 1'b0;
      fs_q <= 1'b0;
      fd_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      wcnt_q <= end_win ? '0 : wcnt_q + 1'b1;
      mv_q <= end_win;
      fs_q <= (fs_q & ~clr_fault) | (cls == CL_ILL);
      fd_q <= (fd_q & ~clr_fault) | dt_pulse;
      for (int i = 0; i < 4; i++) begin
        acc_q[i] <= end_win ? '0 : acc_d[i];
        cnt_q[i] <= end_win ? acc_d[i] : cnt_q[i];
      end
    end
  end
  assign meas_valid = mv_q;
  assign cnt_off = cnt_q[0];
  assign cnt_a = cnt_q[1];
  assign cnt_b = cnt_q[2];
  assign cnt_brake = cnt_q[3];
  assign fault_shoot = fs_q;
  assign fault_dt = fd_q;
endmodule

// File: tb/tb_hbridge_monitor.sv
// tb_hbridge_monitor: directed self-checking bench for hbridge_monitor
module tb_hbridge_monitor;
  localparam int CW = 8;
  localparam logic [3:0] OFF = 4'b0000, A = 4'b1001, B = 4'b0110, BRK = 4'b1010;
  logic clk = 1'b0, reset = 1'b1, clr_fault = 1'b0;
  logic [3:0] hb_in = 4'b0000;
  logic [CW-1:0] period = 8'd99;
  logic meas_valid, fault_shoot, fault_dt;
  logic [CW-1:0] cnt_a, cnt_b, cnt_brake, cnt_off;
  logic [1:0] last_active;
  int pass_n = 0, tot_n = 0, mv_cnt = 0;
  hbridge_monitor #(.DEAD_TIME(10), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .hb_in(hb_in), .period(period), .clr_fault(clr_fault),
    .meas_valid(meas_valid), .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_brake(cnt_brake), .cnt_off(cnt_off),
    .last_active(last_active), .fault_shoot(fault_shoot), .fault_dt(fault_dt)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic [3:0] v, input int n);
    repeat (n) begin
      hb_in = v;
      @(posedge clk);
      #1;
      if (meas_valid) mv_cnt++;
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(OFF, 2);
    reset = 1'b0;
    mv_cnt = 0;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    cyc(4'b1100, 3);
    reset = 1'b0;
    mv_cnt = 0;
    tot_n++;
    if ({meas_valid, cnt_a, cnt_b, cnt_brake, cnt_off, last_active, fault_shoot, fault_dt} !== '0)
      $display("FAIL reset_outputs got mv=%b a=%0d b=%0d br=%0d off=%0d la=%0d fs=%b fd=%b exp all 0",
               meas_valid, cnt_a, cnt_b, cnt_brake, cnt_off, last_active, fault_shoot, fault_dt);
    else pass_n++;
  endtask
  task automatic test_window();
    do_reset();
    period = 8'd99;
    for (int w = 0; w < 2; w++) begin
      cyc(A, 30);
      cyc(B, 69);
      tot_n++;
      if (mv_cnt !== w) $display("FAIL win_early_mv got %0d exp %0d", mv_cnt, w); else pass_n++;
      cyc(B, 1);
      tot_n++;
      if (meas_valid !== 1'b1) $display("FAIL win_mv got %b exp 1", meas_valid); else pass_n++;
      tot_n++;
      if ({cnt_a, cnt_b, cnt_brake, cnt_off} !== {8'd30, 8'd70, 8'd0, 8'd0})
        $display("FAIL win_counts got a=%0d b=%0d br=%0d off=%0d exp 30 70 0 0", cnt_a, cnt_b, cnt_brake, cnt_off);
      else pass_n++;
    end
    tot_n++;
    if (fault_dt !== 1'b1) $display("FAIL win_fault_dt got %b exp 1", fault_dt); else pass_n++;
    tot_n++;
    if (last_active !== 2'd2) $display("FAIL win_last got %0d exp 2", last_active); else pass_n++;
  endtask
  task automatic test_deadtime();
    do_reset();
    period = 8'd200;
    cyc(A, 20);
    cyc(OFF, 10);
    cyc(B, 20);
    cyc(OFF, 10);
    tot_n++;
    if ({fault_dt, fault_shoot, last_active} !== 4'b0010)
      $display("FAIL dt_ok got fd=%b fs=%b la=%0d exp 0 0 2", fault_dt, fault_shoot, last_active);
    else pass_n++;
    cyc(A, 20);
    cyc(OFF, 9);
    tot_n++;
    if ({fault_dt, last_active} !== 3'b001) $display("FAIL dt_pre got fd=%b la=%0d exp 0 1", fault_dt, last_active); else pass_n++;
    cyc(B, 1);
    tot_n++;
    if (fault_dt !== 1'b1) $display("FAIL dt_short got %b exp 1", fault_dt); else pass_n++;
  endtask
  task automatic test_same_leg();
    do_reset();
    cyc(A, 5);
    cyc(OFF, 3);
    cyc(A, 5);
    tot_n++;
    if ({fault_dt, last_active} !== 3'b001) $display("FAIL same_leg got fd=%b la=%0d exp 0 1", fault_dt, last_active); else pass_n++;
    cyc(OFF, 10);
    cyc(BRK, 1);
    tot_n++;
    if ({fault_dt, last_active} !== 3'b011) $display("FAIL brake_entry got fd=%b la=%0d exp 0 3", fault_dt, last_active); else pass_n++;
    cyc(4'b1111, 1);
    tot_n++;
    if ({fault_shoot, last_active} !== 3'b111) $display("FAIL ill_last got fs=%b la=%0d exp 1 3", fault_shoot, last_active); else pass_n++;
    cyc(B, 1);
    tot_n++;
    if ({fault_dt, last_active} !== 3'b010) $display("FAIL idle_entry got fd=%b la=%0d exp 0 2", fault_dt, last_active); else pass_n++;
  endtask
  task automatic test_shoot();
    do_reset();
    period = 8'd9;
    cyc(4'b1100, 1);
    tot_n++;
    if ({fault_shoot, fault_dt} !== 2'b10) $display("FAIL shoot_set got fs=%b fd=%b exp 1 0", fault_shoot, fault_dt); else pass_n++;
    cyc(OFF, 9);
    tot_n++;
    if ({meas_valid, cnt_off, cnt_a, cnt_b, cnt_brake} !== {1'b1, 8'd9, 24'd0})
      $display("FAIL shoot_counts got mv=%b off=%0d a=%0d b=%0d br=%0d exp 1 9 0 0 0", meas_valid, cnt_off, cnt_a, cnt_b, cnt_brake);
    else pass_n++;
    clr_fault = 1'b1;
    cyc(OFF, 1);
    clr_fault = 1'b0;
    tot_n++;
    if (fault_shoot !== 1'b0) $display("FAIL shoot_clr got %b exp 0", fault_shoot); else pass_n++;
    clr_fault = 1'b1;
    cyc(4'b0011, 1);
    clr_fault = 1'b0;
    tot_n++;
    if (fault_shoot !== 1'b1) $display("FAIL shoot_clr_coincident got %b exp 1", fault_shoot); else pass_n++;
  endtask
  task automatic test_period_change();
    do_reset();
    period = 8'd99;
    cyc(OFF, 50);
    tot_n++;
    if (mv_cnt !== 0) $display("FAIL pc_early got %0d exp 0", mv_cnt); else pass_n++;
    period = 8'd9;
    cyc(OFF, 1);
    tot_n++;
    if ({meas_valid, cnt_off} !== {1'b1, 8'd51}) $display("FAIL pc_cut got mv=%b off=%0d exp 1 51", meas_valid, cnt_off); else pass_n++;
    mv_cnt = 0;
    cyc(OFF, 9);
    tot_n++;
    if (mv_cnt !== 0) $display("FAIL pc_gap got %0d exp 0", mv_cnt); else pass_n++;
    cyc(OFF, 1);
    tot_n++;
    if ({mv_cnt, meas_valid, cnt_off} !== {32'd1, 1'b1, 8'd10}) $display("FAIL pc_short got n=%0d mv=%b off=%0d exp 1 1 10", mv_cnt, meas_valid, cnt_off); else pass_n++;
  endtask
  task automatic test_reset_mid();
    period = 8'd99;
    cyc(A, 40);
    reset = 1'b1;
    cyc(A, 1);
    reset = 1'b0;
    mv_cnt = 0;
    tot_n++;
    if ({meas_valid, cnt_a, cnt_b, cnt_brake, cnt_off} !== '0)
      $display("FAIL mid_reset got mv=%b a=%0d b=%0d br=%0d off=%0d exp all 0", meas_valid, cnt_a, cnt_b, cnt_brake, cnt_off);
    else pass_n++;
    cyc(OFF, 99);
    tot_n++;
    if (mv_cnt !== 0) $display("FAIL mid_no_mv got %0d exp 0", mv_cnt); else pass_n++;
    cyc(OFF, 1);
    tot_n++;
    if ({meas_valid, cnt_off, cnt_a} !== {1'b1, 8'd100, 8'd0}) $display("FAIL mid_fresh got mv=%b off=%0d a=%0d exp 1 100 0", meas_valid, cnt_off, cnt_a); else pass_n++;
  endtask
  task automatic test_saturate();
    do_reset();
    period = 8'd255;
    cyc(OFF, 255);
    tot_n++;
    if (mv_cnt !== 0) $display("FAIL sat_early got %0d exp 0", mv_cnt); else pass_n++;
    cyc(OFF, 1);
    tot_n++;
    if ({meas_valid, cnt_off} !== {1'b1, 8'd255}) $display("FAIL sat_off got mv=%b off=%0d exp 1 255", meas_valid, cnt_off); else pass_n++;
  endtask
  initial begin
    test_reset();
    test_window();
    test_deadtime();
    test_same_leg();
    test_shoot();
    test_period_change();
    test_reset_mid();
    test_saturate();
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule
